// File: rtl/pps_housekeeping_packetizer_pkg.sv
// Shared constants, state encoding and snapshot payload for the PPS housekeeping packetizer.
package pps_housekeeping_packetizer_pkg;

    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEQ_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned HDR_W = 12;
    localparam int unsigned SEC_W = 32;

    localparam logic [HDR_W-1:0] HEADER_ID_DEFAULT = 12'hD7A;
    localparam int unsigned      PKT_WORDS         = 5;

    localparam logic [IDX_W-1:0] W_HDR  = 3'd0;
    localparam logic [IDX_W-1:0] W_SECH = 3'd1;
    localparam logic [IDX_W-1:0] W_SECL = 3'd2;
    localparam logic [IDX_W-1:0] W_DT   = 3'd3;
    localparam logic [IDX_W-1:0] W_CSUM = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [SEC_W-1:0] sec;
        logic [DAT_W-1:0] dt;
    } hk_snap_t;

endpackage

// File: rtl/hk_word_mux.sv
// Combinational packet word select; word 4 is the XOR of words 0..3.
module hk_word_mux
    import pps_housekeeping_packetizer_pkg::*;
#(
    parameter logic [HDR_W-1:0] HEADER_ID = HEADER_ID_DEFAULT
) (
    input  hk_snap_t         i_snap,
    input  logic [IDX_W-1:0] i_idx,
    output logic [DAT_W-1:0] o_word
);

    logic [DAT_W-1:0] w_w0;
    logic [DAT_W-1:0] w_w1;
    logic [DAT_W-1:0] w_w2;
    logic [DAT_W-1:0] w_w3;
    logic [DAT_W-1:0] w_csum;

    assign w_w0   = {HEADER_ID, i_snap.seq};
    assign w_w1   = i_snap.sec[SEC_W-1:DAT_W];
    assign w_w2   = i_snap.sec[DAT_W-1:0];
    assign w_w3   = i_snap.dt;
    assign w_csum = w_w0 ^ w_w1 ^ w_w2 ^ w_w3;

    always_comb begin
        o_word = '0;
        case (i_idx)
            W_HDR:   o_word = w_w0;
            W_SECH:  o_word = w_w1;
            W_SECL:  o_word = w_w2;
            W_DT:    o_word = w_w3;
            W_CSUM:  o_word = w_csum;
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/pps_housekeeping_packetizer.sv
// Snaps deadtime and seconds count on PPS and streams them as a 5-word checksummed packet.
module pps_housekeeping_packetizer
    import pps_housekeeping_packetizer_pkg::*;
#(
    parameter logic [HDR_W-1:0] HEADER_ID = HEADER_ID_DEFAULT,
    parameter int unsigned      SEC_WIDTH = 32
) (
    input  logic             clk33_i,
    input  logic             rst_n_i,
    input  logic             pps_clk33_i,
    input  logic [DAT_W-1:0] deadtime_i,
    output logic [DAT_W-1:0] dat_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             overrun_o,
    input  logic             clr_overrun_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DAT_W-1:0]     r_dat;
    logic [DAT_W-1:0]     w_dat_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_last;
    logic                 w_last_nxt;
    logic                 r_ovr;
    logic                 w_ovr_nxt;
    logic [SEC_WIDTH-1:0] r_sec_cnt;
    logic [SEC_WIDTH-1:0] w_sec_cnt_nxt;
    logic [SEQ_W-1:0]     r_seq;
    logic [SEQ_W-1:0]     w_seq_nxt;
    logic [SEC_W-1:0]     r_sec_snap;
    logic [SEC_W-1:0]     w_sec_snap_nxt;
    logic [DAT_W-1:0]     r_dt_snap;
    logic [DAT_W-1:0]     w_dt_snap_nxt;

    logic                 w_xfer;
    logic                 w_idx_last;
    logic                 w_ovr_set;
    logic [IDX_W-1:0]     w_idx_inc;
    logic [IDX_W-1:0]     w_mux_idx;
    logic [DAT_W-1:0]     w_word;
    hk_snap_t             w_snap;

    assign w_xfer     = r_valid & ready_i;
    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_idx_inc  = r_idx + IDX_W'(1);

    // In CAPTURE the snapshot registers are still loading, so word 0 is built from the live sources.
    assign w_snap.seq = r_seq;
    assign w_snap.sec = (r_state == CAPTURE) ? SEC_W'(r_sec_cnt) : r_sec_snap;
    assign w_snap.dt  = (r_state == CAPTURE) ? deadtime_i : r_dt_snap;
    assign w_mux_idx  = (r_state == CAPTURE) ? W_HDR : w_idx_inc;

    hk_word_mux #(
        .HEADER_ID (HEADER_ID)
    ) u_word_mux (
        .i_snap (w_snap),
        .i_idx  (w_mux_idx),
        .o_word (w_word)
    );

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_dat      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_ovr      <= 1'b0;
            r_sec_cnt  <= '0;
            r_seq      <= '0;
            r_sec_snap <= '0;
            r_dt_snap  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_dat      <= w_dat_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_ovr      <= w_ovr_nxt;
            r_sec_cnt  <= w_sec_cnt_nxt;
            r_seq      <= w_seq_nxt;
            r_sec_snap <= w_sec_snap_nxt;
            r_dt_snap  <= w_dt_snap_nxt;
        end
    end

    // A PPS landing on the final transfer chains straight into the next capture.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (pps_clk33_i) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = SEND;
            SEND:    if (w_xfer && w_idx_last) w_state_nxt = pps_clk33_i ? CAPTURE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt      = r_idx;
        w_dat_nxt      = r_dat;
        w_valid_nxt    = r_valid;
        w_last_nxt     = r_last;
        w_seq_nxt      = r_seq;
        w_sec_snap_nxt = r_sec_snap;
        w_dt_snap_nxt  = r_dt_snap;
        w_sec_cnt_nxt  = r_sec_cnt + SEC_WIDTH'(pps_clk33_i);
        w_ovr_set      = pps_clk33_i &&
                         ((r_state == CAPTURE) || ((r_state == SEND) && !(w_xfer && w_idx_last)));
        w_ovr_nxt      = w_ovr_set | (r_ovr & ~clr_overrun_i);

        case (r_state)
            CAPTURE: begin
                w_sec_snap_nxt = SEC_W'(r_sec_cnt);
                w_dt_snap_nxt  = deadtime_i;
                w_idx_nxt      = W_HDR;
                w_dat_nxt      = w_word;
                w_valid_nxt    = 1'b1;
                w_last_nxt     = 1'b0;
            end
            SEND: begin
                if (w_xfer) begin
                    if (w_idx_last) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_dat_nxt   = '0;
                        w_seq_nxt   = r_seq + SEQ_W'(1);
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_dat_nxt  = w_word;
                        w_last_nxt = (w_idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign dat_o     = r_dat;
    assign valid_o   = r_valid;
    assign last_o    = r_last;
    assign overrun_o = r_ovr;

endmodule

// File: tb/tb_pps_housekeeping_packetizer.sv
// Randomized bench for pps_housekeeping_packetizer against a packet-queue reference model.
module tb_pps_housekeeping_packetizer;

    logic        clk33_i = 1'b0;
    logic        rst_n_i;
    logic        pps_clk33_i;
    logic [15:0] deadtime_i;
    logic [15:0] dat_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        overrun_o;
    logic        clr_overrun_i;

    int n_total = 0;
    int n_bad   = 0;

    always #15 clk33_i = ~clk33_i;

    pps_housekeeping_packetizer u_dut (
        .clk33_i       (clk33_i),
        .rst_n_i       (rst_n_i),
        .pps_clk33_i   (pps_clk33_i),
        .deadtime_i    (deadtime_i),
        .dat_o         (dat_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .last_o        (last_o),
        .overrun_o     (overrun_o),
        .clr_overrun_i (clr_overrun_i)
    );

    // Reference model: expected words of the packet in flight, plus the capture gap before it shows.
    logic [31:0] m_sec;
    logic [3:0]  m_seq;
    logic [15:0] m_q[$];
    int          m_delay;
    logic        m_ovr;
    logic [15:0] dt_next;
    logic        dt_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_sec   = 32'd0;
        m_seq   = 4'd0;
        m_delay = 0;
        m_ovr   = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step(input logic pps, input logic rdy, input logic clr, input logic [15:0] dt);
        bit          pending;
        bit          xfer;
        bit          done;
        bit          setv;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        pending = (m_q.size() != 0);
        xfer    = pending && (m_delay == 0) && rdy;
        done    = xfer && (m_q.size() == 1);
        setv    = 1'b0;
        if (xfer) void'(m_q.pop_front());
        if (done) m_seq = m_seq + 4'd1;
        if (pending && m_delay > 0) m_delay--;
        if (pps) begin
            m_sec = m_sec + 32'd1;
            if (!pending || done) begin
                w0 = {12'hD7A, m_seq};
                w1 = m_sec[31:16];
                w2 = m_sec[15:0];
                m_q.push_back(w0);
                m_q.push_back(w1);
                m_q.push_back(w2);
                m_q.push_back(dt);
                m_q.push_back(w0 ^ w1 ^ w2 ^ dt);
                m_delay = 1;
            end else begin
                setv = 1'b1;
            end
        end
        if (setv) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    // One clock: compare outputs from the last edge, then drive and model the next edge.
    task automatic cyc(input logic pps, input logic rdy, input logic clr, input logic [15:0] dt);
        bit vis;
        @(negedge clk33_i);
        vis = (m_q.size() != 0) && (m_delay == 0);
        check("valid", 32'(valid_o), 32'(vis));
        if (vis) begin
            check("dat", 32'(dat_o), 32'(m_q[0]));
            check("last", 32'(last_o), 32'(m_q.size() == 1));
        end
        check("overrun", 32'(overrun_o), 32'(m_ovr));
        if (dt_pend) begin
            deadtime_i = dt_next;
            dt_pend    = 1'b0;
        end
        pps_clk33_i   = pps;
        ready_i       = rdy;
        clr_overrun_i = clr;
        if (pps) begin
            dt_next = dt;
            dt_pend = 1'b1;
        end
        model_step(pps, rdy, clr, dt);
    endtask

    initial begin
        rst_n_i       = 1'b0;
        pps_clk33_i   = 1'b0;
        ready_i       = 1'b0;
        clr_overrun_i = 1'b0;
        deadtime_i    = 16'h0000;
        dt_next       = 16'h0000;
        dt_pend       = 1'b0;
        model_reset();
        #50;
        check("rst_dat", 32'(dat_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        @(negedge clk33_i);
        rst_n_i = 1'b1;

        // first packet, fixed deadtime
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0123);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);

        // widely spaced PPS
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
            for (int i = 0; i < 999; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        end

        // back-pressure pattern 1,0,0,1,0,0...
        cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 30; i++) cyc(1'b0, (i % 3) == 2, 1'b0, 16'h0);

        // stalled sink, second PPS overruns
        cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
        for (int i = 0; i < 19; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);

        // clear, then clear colliding with a new overrun
        cyc(1'b0, 1'b1, 1'b1, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
        cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 16'($urandom));
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);

        // PPS on the final transfer chains into the next packet
        cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);

        // reset while word 2 is on the bus
        cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        pps_clk33_i = 1'b0;
        #3 rst_n_i = 1'b0;
        #1;
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_last", 32'(last_o), 32'd0);
        model_reset();
        @(negedge clk33_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, 16'($urandom));
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
